// File: rtl/joyport_arbiter_if.sv
// ---------------------------------------------------------------------------
// joyport_arbiter_if
// Bundles the host-side device streams (joysticks, PS/2 mouse) and the
// MSX-side joystick port signals handled by joyport_arbiter.
//   swap          static port preference (0: joy_0->A, joy_1->B)
//   joy_0/joy_1   active-high joystick bits [0]R [1]L [2]D [3]U [4]F1 [5]F2
//   mouse_x/y     signed movement deltas, valid with mouse_strobe
//   mouse_flags   [1:0] mouse buttons, active-high
//   mouse_strobe  one-cycle pulse announcing a new delta
//   stra/strb     pin-8 strobes from the MSX core for ports A and B
//   pa_n/pb_n     port line levels, 1 = released
//   owner_a/b     0 none, 1 joy_0, 2 joy_1, 3 mouse
// ---------------------------------------------------------------------------
interface joyport_arbiter_if;
  logic              swap;
  logic [5:0]        joy_0;
  logic [5:0]        joy_1;
  logic signed [8:0] mouse_x;
  logic signed [8:0] mouse_y;
  logic [7:0]        mouse_flags;
  logic              mouse_strobe;
  logic              stra;
  logic              strb;
  logic [5:0]        pa_n;
  logic [5:0]        pb_n;
  logic [1:0]        owner_a;
  logic [1:0]        owner_b;

  modport slave (
    input  swap, joy_0, joy_1, mouse_x, mouse_y, mouse_flags, mouse_strobe,
    input  stra, strb,
    output pa_n, pb_n, owner_a, owner_b
  );

  modport master (
    output swap, joy_0, joy_1, mouse_x, mouse_y, mouse_flags, mouse_strobe,
    output stra, strb,
    input  pa_n, pb_n, owner_a, owner_b
  );
endinterface

// File: rtl/joyport_arbiter.sv
// ---------------------------------------------------------------------------
// joyport_arbiter
// Decides every cycle which host device (joy_0, joy_1, PS/2 mouse) drives
// each MSX joystick port, and runs the MSX mouse protocol: a strobe-driven
// 4-nibble shifter fed by a saturating delta accumulator, with a timeout
// that returns the sequencer to the first nibble.
// Ports:
//   clk_sys  system clock (only clock)
//   reset    synchronous, active-high
//   bus      joyport_arbiter_if.slave (device inputs, port outputs, owners)
// All outputs are registered.
// ---------------------------------------------------------------------------
module joyport_arbiter #(
  parameter logic [23:0] IDLE_TIMEOUT  = 24'd2_000_000,
  parameter logic [17:0] MOUSE_TIMEOUT = 18'd100000
) (
  input  logic               clk_sys,
  input  logic               reset,
  joyport_arbiter_if.slave   bus
);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_J0    = 2'd1;
  localparam logic [1:0] OWN_J1    = 2'd2;
  localparam logic [1:0] OWN_MOUSE = 2'd3;

  localparam logic [1:0] PORT_NONE = 2'd0;
  localparam logic [1:0] PORT_A    = 2'd1;
  localparam logic [1:0] PORT_B    = 2'd2;

  typedef enum logic [1:0] {N0, N1, N2, N3} seq_state_e;

  // Clamp a 10-bit signed value into the signed 8-bit range.
  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'sd127;
    else if (v < -10'sd128) return -8'sd128;
    else                    return v[7:0];
  endfunction

  function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                  input logic signed [7:0] b);
    logic signed [9:0] s;
    s = 10'(a) + 10'(b);
    return sat8(s);
  endfunction

  // Line levels of one port for a given owner; a joystick line is pulled low
  // only while its bit is set and the port strobe is low.
  function automatic logic [5:0] port_lines(input logic [1:0] own,
                                            input logic       stb,
                                            input logic [5:0] j0,
                                            input logic [5:0] j1,
                                            input logic [1:0] btn,
                                            input logic [3:0] nib);
    case (own)
      OWN_J0:    return ~(j0 & {6{~stb}});
      OWN_J1:    return ~(j1 & {6{~stb}});
      OWN_MOUSE: return {~btn, nib};
      default:   return 6'h3F;
    endcase
  endfunction

  logic [1:0]        owner_a_q, owner_a_d, owner_b_q, owner_b_d;
  logic [23:0]       idle_a_q, idle_a_d, idle_b_q, idle_b_d;
  logic [5:0]        pa_n_q, pa_n_d, pb_n_q, pb_n_d;
  seq_state_e        state_q, state_d;
  logic signed [7:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [7:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [17:0]       mto_q, mto_d;
  logic              stb_q, stb_d;

  logic [1:0]        pref_a, pref_b;
  logic              act_a, act_b;
  logic              own_act_a, own_act_b;
  logic              displaced_a, displaced_b;
  logic [1:0]        mport_q, mport_d;
  logic              stb_sel, own_change, stb_edge;
  logic signed [9:0] neg_x;
  logic signed [7:0] dx_sat, dy_sat;
  logic              unused_flags;

  assign unused_flags = &{1'b0, bus.mouse_flags[7:2]};

  // X is reported with inverted sign on the MSX side.
  assign neg_x  = -$signed({bus.mouse_x[8], bus.mouse_x});
  assign dx_sat = sat8(neg_x);
  assign dy_sat = sat8($signed({bus.mouse_y[8], bus.mouse_y}));

  assign pref_a = bus.swap ? OWN_J1 : OWN_J0;
  assign pref_b = bus.swap ? OWN_J0 : OWN_J1;
  assign act_a  = bus.swap ? |bus.joy_1 : |bus.joy_0;
  assign act_b  = bus.swap ? |bus.joy_0 : |bus.joy_1;

  // Activity of whoever currently owns each port keeps its idle counter at 0.
  always_comb begin
    own_act_a = 1'b0;
    own_act_b = 1'b0;
    case (owner_a_q)
      OWN_J0:    own_act_a = |bus.joy_0;
      OWN_J1:    own_act_a = |bus.joy_1;
      OWN_MOUSE: own_act_a = bus.mouse_strobe;
      default:   own_act_a = 1'b0;
    endcase
    case (owner_b_q)
      OWN_J0:    own_act_b = |bus.joy_0;
      OWN_J1:    own_act_b = |bus.joy_1;
      OWN_MOUSE: own_act_b = bus.mouse_strobe;
      default:   own_act_b = 1'b0;
    endcase
  end

  // Ownership: idle release first, then joystick claims (which may push the
  // mouse to the other port), then the mouse claim on its strobe.
  always_comb begin
    owner_a_d   = owner_a_q;
    owner_b_d   = owner_b_q;
    displaced_a = 1'b0;
    displaced_b = 1'b0;

    if (owner_a_q != OWN_NONE && idle_a_q >= IDLE_TIMEOUT) owner_a_d = OWN_NONE;
    if (owner_b_q != OWN_NONE && idle_b_q >= IDLE_TIMEOUT) owner_b_d = OWN_NONE;

    if (act_a) begin
      if (owner_a_d == OWN_MOUSE) displaced_a = 1'b1;
      owner_a_d = pref_a;
    end
    if (act_b) begin
      if (owner_b_d == OWN_MOUSE) displaced_b = 1'b1;
      owner_b_d = pref_b;
    end
    if (displaced_a && owner_b_d == OWN_NONE) owner_b_d = OWN_MOUSE;
    if (displaced_b && owner_a_d == OWN_NONE) owner_a_d = OWN_MOUSE;

    if (bus.mouse_strobe) begin
      if (owner_a_d == OWN_NONE || owner_a_d == OWN_MOUSE) begin
        owner_a_d = OWN_MOUSE;
        // The mouse never holds both ports.
        if (owner_b_d == OWN_MOUSE) owner_b_d = OWN_NONE;
      end else if (owner_b_d == OWN_NONE || owner_b_d == OWN_MOUSE) begin
        owner_b_d = OWN_MOUSE;
      end
    end
  end

  always_comb begin
    idle_a_d = idle_a_q;
    idle_b_d = idle_b_q;
    if (owner_a_d != owner_a_q || own_act_a || owner_a_q == OWN_NONE) idle_a_d = '0;
    else if (idle_a_q < IDLE_TIMEOUT)                                  idle_a_d = idle_a_q + 24'd1;
    if (owner_b_d != owner_b_q || own_act_b || owner_b_q == OWN_NONE) idle_b_d = '0;
    else if (idle_b_q < IDLE_TIMEOUT)                                  idle_b_d = idle_b_q + 24'd1;
  end

  // Mouse port tracking. The strobe register follows the port the mouse will
  // own next cycle, so a port change never looks like a strobe edge.
  assign mport_q    = (owner_a_q == OWN_MOUSE) ? PORT_A :
                      (owner_b_q == OWN_MOUSE) ? PORT_B : PORT_NONE;
  assign mport_d    = (owner_a_d == OWN_MOUSE) ? PORT_A :
                      (owner_b_d == OWN_MOUSE) ? PORT_B : PORT_NONE;
  assign stb_sel    = (mport_q == PORT_B) ? bus.strb : bus.stra;
  assign stb_d      = (mport_d == PORT_B) ? bus.strb : bus.stra;
  assign own_change = (mport_d != mport_q);
  assign stb_edge   = (mport_q != PORT_NONE) && !own_change && (stb_sel != stb_q);

  always_comb begin
    state_d  = state_q;
    nibble_d = nibble_q;
    snap_x_d = snap_x_q;
    snap_y_d = snap_y_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    mto_d    = mto_q;

    if (bus.mouse_strobe) begin
      acc_x_d = sat_add8(acc_x_q, dx_sat);
      acc_y_d = sat_add8(acc_y_q, dy_sat);
    end

    if (own_change) begin
      state_d = N0;
      mto_d   = '0;
    end else if (stb_edge) begin
      mto_d = MOUSE_TIMEOUT;
      case (state_q)
        N0: begin
          // Snapshot takes the old totals; a coincident delta starts the next read.
          nibble_d = acc_x_q[7:4];
          snap_x_d = acc_x_q;
          snap_y_d = acc_y_q;
          acc_x_d  = bus.mouse_strobe ? dx_sat : 8'sd0;
          acc_y_d  = bus.mouse_strobe ? dy_sat : 8'sd0;
          state_d  = N1;
        end
        N1: begin
          nibble_d = snap_x_q[3:0];
          state_d  = N2;
        end
        N2: begin
          nibble_d = snap_y_q[7:4];
          state_d  = N3;
        end
        default: begin
          nibble_d = snap_y_q[3:0];
          state_d  = N0;
        end
      endcase
    end else if (mto_q == 18'd1) begin
      state_d = N0;
      mto_d   = '0;
    end else if (mto_q != '0) begin
      mto_d = mto_q - 18'd1;
    end
  end

  assign pa_n_d = port_lines(owner_a_q, bus.stra, bus.joy_0, bus.joy_1,
                             bus.mouse_flags[1:0], nibble_q);
  assign pb_n_d = port_lines(owner_b_q, bus.strb, bus.joy_0, bus.joy_1,
                             bus.mouse_flags[1:0], nibble_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      owner_a_q <= OWN_NONE;
      owner_b_q <= OWN_NONE;
      idle_a_q  <= '0;
      idle_b_q  <= '0;
      pa_n_q    <= 6'h3F;
      pb_n_q    <= 6'h3F;
      state_q   <= N0;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      snap_x_q  <= '0;
      snap_y_q  <= '0;
      nibble_q  <= '0;
      mto_q     <= '0;
      stb_q     <= 1'b0;
    end else begin
      owner_a_q <= owner_a_d;
      owner_b_q <= owner_b_d;
      idle_a_q  <= idle_a_d;
      idle_b_q  <= idle_b_d;
      pa_n_q    <= pa_n_d;
      pb_n_q    <= pb_n_d;
      state_q   <= state_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      snap_x_q  <= snap_x_d;
      snap_y_q  <= snap_y_d;
      nibble_q  <= nibble_d;
      mto_q     <= mto_d;
      stb_q     <= stb_d;
    end
  end

  assign bus.pa_n    = pa_n_q;
  assign bus.pb_n    = pb_n_q;
  assign bus.owner_a = owner_a_q;
  assign bus.owner_b = owner_b_q;

endmodule

// File: tb/tb_joyport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_joyport_arbiter
// Scenario bench for joyport_arbiter. Timeouts are shortened through the
// parameters so every scenario fits in a few thousand cycles. Expected mouse
// nibbles come from a small behavioural model of the accumulator/sequencer
// and are queued when a strobe edge is driven, then popped when the nibble
// is due on the port lines.
// ---------------------------------------------------------------------------
module tb_joyport_arbiter;
  localparam int IDLE_T  = 2000;
  localparam int MOUSE_T = 300;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  joyport_arbiter_if bus();

  joyport_arbiter #(
    .IDLE_TIMEOUT (24'd2000),
    .MOUSE_TIMEOUT(18'd300)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_acc_x, m_acc_y, m_snap_x, m_snap_y, m_state;

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic model_clear();
    m_acc_x = 0; m_acc_y = 0; m_snap_x = 0; m_snap_y = 0; m_state = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    bus.swap = 1'b0; bus.joy_0 = '0; bus.joy_1 = '0;
    bus.mouse_x = '0; bus.mouse_y = '0; bus.mouse_flags = '0;
    bus.mouse_strobe = 1'b0; bus.stra = 1'b0; bus.strb = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic mouse_pulse(input int dx, input int dy);
    bus.mouse_x = 9'(dx);
    bus.mouse_y = 9'(dy);
    bus.mouse_strobe = 1'b1;
    m_acc_x = sat(m_acc_x + sat(-dx));
    m_acc_y = sat(m_acc_y + sat(dy));
    tick(1);
    bus.mouse_strobe = 1'b0;
  endtask

  // One strobe edge on the mouse port, optionally with a coincident delta.
  task automatic strobe_edge(input string name, input bit on_b,
                             input bit with_delta, input int dx, input int dy);
    int e;
    logic [3:0] nib;
    case (m_state)
      0: begin
        e = (m_acc_x & 255) >> 4;
        m_snap_x = m_acc_x;
        m_snap_y = m_acc_y;
        m_acc_x = with_delta ? sat(-dx) : 0;
        m_acc_y = with_delta ? sat(dy) : 0;
      end
      1: e = m_snap_x & 15;
      2: e = (m_snap_y & 255) >> 4;
      default: e = m_snap_y & 15;
    endcase
    if (with_delta && m_state != 0) begin
      m_acc_x = sat(m_acc_x + sat(-dx));
      m_acc_y = sat(m_acc_y + sat(dy));
    end
    m_state = (m_state + 1) % 4;
    exp_q.push_back(e);

    if (on_b) bus.strb = ~bus.strb;
    else      bus.stra = ~bus.stra;
    if (with_delta) begin
      bus.mouse_x = 9'(dx);
      bus.mouse_y = 9'(dy);
      bus.mouse_strobe = 1'b1;
    end
    tick(1);
    bus.mouse_strobe = 1'b0;
    tick(1);

    nib = on_b ? bus.pb_n[3:0] : bus.pa_n[3:0];
    e = exp_q.pop_front();
    checks++;
    if (nib !== 4'(e)) begin
      errors++;
      $display("FAIL %s: nibble got %0h expected %0h", name, nib, e);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.owner_a !== 2'd0) begin errors++; $display("FAIL reset_owner_a: got %0d expected 0", bus.owner_a); end
    checks++; if (bus.owner_b !== 2'd0) begin errors++; $display("FAIL reset_owner_b: got %0d expected 0", bus.owner_b); end
    checks++; if (bus.pa_n !== 6'h3F) begin errors++; $display("FAIL reset_pa_n: got %b expected 111111", bus.pa_n); end
    checks++; if (bus.pb_n !== 6'h3F) begin errors++; $display("FAIL reset_pb_n: got %b expected 111111", bus.pb_n); end
  endtask

  task automatic test_joystick();
    do_reset();
    bus.joy_0 = 6'b010000;
    tick(1);
    checks++; if (bus.owner_a !== 2'd1) begin errors++; $display("FAIL joy_owner_a: got %0d expected 1", bus.owner_a); end
    checks++; if (bus.owner_b !== 2'd0) begin errors++; $display("FAIL joy_owner_b: got %0d expected 0", bus.owner_b); end
    tick(1);
    checks++; if (bus.pa_n !== 6'b101111) begin errors++; $display("FAIL joy_pa_n: got %b expected 101111", bus.pa_n); end
    checks++; if (bus.pb_n !== 6'h3F) begin errors++; $display("FAIL joy_pb_n: got %b expected 111111", bus.pb_n); end
    bus.joy_0 = 6'b000011;
    tick(1);
    checks++; if (bus.pa_n !== 6'b111100) begin errors++; $display("FAIL joy_change: got %b expected 111100", bus.pa_n); end
    bus.stra = 1'b1;
    tick(1);
    checks++; if (bus.pa_n !== 6'h3F) begin errors++; $display("FAIL joy_strobe_high: got %b expected 111111", bus.pa_n); end
  endtask

  task automatic test_swap();
    do_reset();
    bus.swap = 1'b1;
    bus.joy_0 = 6'b000001;
    tick(1);
    checks++; if (bus.owner_b !== 2'd1 || bus.owner_a !== 2'd0) begin errors++; $display("FAIL swap_owner: got a=%0d b=%0d expected a=0 b=1", bus.owner_a, bus.owner_b); end
    tick(1);
    checks++; if (bus.pb_n[0] !== 1'b0) begin errors++; $display("FAIL swap_pb0_low: got %b expected 0", bus.pb_n[0]); end
    bus.strb = 1'b1;
    tick(1);
    checks++; if (bus.pb_n[0] !== 1'b1) begin errors++; $display("FAIL swap_pb0_strobe: got %b expected 1", bus.pb_n[0]); end
  endtask

  task automatic test_mouse_read();
    do_reset();
    bus.mouse_flags = 8'h01;
    mouse_pulse(-5, 3);
    checks++; if (bus.owner_a !== 2'd3) begin errors++; $display("FAIL mouse_owner_a: got %0d expected 3", bus.owner_a); end
    for (int i = 0; i < 4; i++) strobe_edge("mouse_read", 1'b0, 1'b0, 0, 0);
    checks++; if (bus.pa_n[5:4] !== 2'b10) begin errors++; $display("FAIL mouse_buttons: got %b expected 10", bus.pa_n[5:4]); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 3; i++) mouse_pulse(-100, 0);
    for (int i = 0; i < 4; i++) strobe_edge("saturation", 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    mouse_pulse(-5, 0);
    strobe_edge("simul_edge", 1'b0, 1'b1, -48, 0);
    for (int i = 0; i < 7; i++) strobe_edge("simul_next", 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_displacement();
    do_reset();
    mouse_pulse(0, 0);
    checks++; if (bus.owner_a !== 2'd3) begin errors++; $display("FAIL disp_mouse_a: got %0d expected 3", bus.owner_a); end
    strobe_edge("disp_first", 1'b0, 1'b0, 0, 0);
    bus.joy_0 = 6'b000001;
    tick(1);
    checks++; if (bus.owner_a !== 2'd1 || bus.owner_b !== 2'd3) begin errors++; $display("FAIL disp_owners: got a=%0d b=%0d expected a=1 b=3", bus.owner_a, bus.owner_b); end
    m_state = 0;
    mouse_pulse(-32, 0);
    strobe_edge("disp_seq_n0", 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_drop();
    do_reset();
    bus.joy_0 = 6'b000100;
    bus.joy_1 = 6'b001000;
    tick(1);
    mouse_pulse(-1, 1);
    checks++; if (bus.owner_a !== 2'd1 || bus.owner_b !== 2'd2) begin errors++; $display("FAIL mouse_drop: got a=%0d b=%0d expected a=1 b=2", bus.owner_a, bus.owner_b); end
  endtask

  task automatic test_mouse_timeout();
    do_reset();
    mouse_pulse(-5, 3);
    for (int i = 0; i < 3; i++) strobe_edge("mto_pre", 1'b0, 1'b0, 0, 0);
    mouse_pulse(-80, 0);
    tick(MOUSE_T + 30);
    m_state = 0;
    strobe_edge("mto_n0", 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_idle_timeout();
    int n;
    do_reset();
    mouse_pulse(-5, 3);
    strobe_edge("idle_pre", 1'b0, 1'b0, 0, 0);
    strobe_edge("idle_pre", 1'b0, 1'b0, 0, 0);
    checks++; if (bus.pa_n !== 6'b110101) begin errors++; $display("FAIL idle_lines_owned: got %b expected 110101", bus.pa_n); end
    tick(IDLE_T - 100);
    checks++; if (bus.owner_a !== 2'd3) begin errors++; $display("FAIL idle_early_release: got %0d expected 3", bus.owner_a); end
    n = 0;
    while (bus.owner_a !== 2'd0 && n < 300) begin
      tick(1);
      n++;
    end
    checks++; if (bus.owner_a !== 2'd0) begin errors++; $display("FAIL idle_release: got %0d expected 0 within bound", bus.owner_a); end
    tick(1);
    checks++; if (bus.pa_n !== 6'h3F) begin errors++; $display("FAIL idle_lines: got %b expected 111111", bus.pa_n); end
  endtask

  task automatic test_midreset();
    do_reset();
    mouse_pulse(-5, 3);
    strobe_edge("mid_pre", 1'b0, 1'b0, 0, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_clear();
    checks++; if (bus.owner_a !== 2'd0) begin errors++; $display("FAIL midreset_owner: got %0d expected 0", bus.owner_a); end
    checks++; if (bus.pa_n !== 6'h3F) begin errors++; $display("FAIL midreset_pa_n: got %b expected 111111", bus.pa_n); end
    mouse_pulse(-16, 0);
    strobe_edge("midreset_n0", 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_joystick();
    test_swap();
    test_mouse_read();
    test_saturation();
    test_simultaneous();
    test_displacement();
    test_drop();
    test_mouse_timeout();
    test_idle_timeout();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/joyport_arbiter.md
# joyport_arbiter

Owns both MSX general-purpose joystick ports and decides, cycle by cycle, which host device drives each port: joystick 0, joystick 1 or the PS/2 mouse. Contains the MSX mouse protocol sequencer, a strobe-driven 4-nibble shifter with a saturating delta accumulator and a timeout. Sits between user_io (joystick and mouse streams) and emsx_top (pJoyA/pJoyB, pStra/pStrb).

## Interface
Parameters:
- IDLE_TIMEOUT, 24'd2_000_000 — cycles without activity before a port owner is released.
- MOUSE_TIMEOUT, 18'd100000 — cycles without a strobe edge before the mouse sequencer returns to nibble 0.

Ports:
- clk_sys  in  1  system clock (21.48 MHz); the only clock.
- reset  in  1  synchronous, active-high.
- swap  in  1  static preference; 0: joy_0→A, joy_1→B; 1: inverted.
- joy_0, joy_1  in  6 each  active-high: [0]R [1]L [2]D [3]U [4]F1 [5]F2.
- mouse_x, mouse_y  in  9 each  signed movement deltas.
- mouse_flags  in  8  [1:0] buttons, active-high.
- mouse_strobe  in  1  one-cycle pulse; new delta valid.
- stra, strb  in  1 each  pin-8 strobe from the MSX core for ports A and B.
- pa_n, pb_n  out  6 each  port line levels, 1 = released; bit order as joy_*.
- owner_a, owner_b  out  2 each  0 none, 1 joy_0, 2 joy_1, 3 mouse.

## Operation
- Preferred joystick of a port: A = swap ? joy_1 : joy_0; B = the other. The mouse has no preferred port.
- Activity: a joystick is active when any of its bits is 1; the mouse is active on mouse_strobe.
- Arbitration is evaluated every cycle, and owners are registered.
  - The preferred joystick takes its port when active. This overrides mouse ownership. A displaced mouse moves to the other port if that port's owner is 0, otherwise the mouse goes to owner 0.
  - On an active mouse: the mouse claims A if owner_a is 0 or 3. Otherwise it claims B if owner_b is 0 or 3. Otherwise the mouse is dropped.
  - The mouse never owns both ports. A joystick owns only its preferred port.
  - Each port has an idle counter, reset on owner activity. When it reaches IDLE_TIMEOUT, the owner becomes 0.
- Joystick drive: for owned bit i, the line is pulled low (pX_n[i]=0) when joy[i]=1 and the port strobe is 0. Otherwise the line is released.
- Unowned port: all lines are 1.
- Mouse accumulator:
  - acc_x and acc_y are 8-bit signed.
  - On mouse_strobe, acc_x += sat8(−mouse_x) and acc_y += sat8(mouse_y).
  - sat8 and the sum both saturate to [−128, 127].
- Mouse sequencer:
  - States N0..N3. The strobe of the owning port is registered (stb_d); an edge is stb ≠ stb_d.
  - On each edge the state advances with wrap N3→N0. The nibble is driven as follows:
    - N0→ snap_x[7:4]; snap_x←acc_x, snap_y←acc_y and the accumulators are cleared in the same cycle.
    - N1→ snap_x[3:0].
    - N2→ snap_y[7:4].
    - N3→ snap_y[3:0].
  - Simultaneous mouse_strobe and N0 edge: the snapshot takes the old accumulator values, and the accumulators load only the new delta.
  - Mouse-owned port lines: pX_n[3:0] = nibble; pX_n[5:4] = ~mouse_flags[1:0].
  - The timeout counter reloads MOUSE_TIMEOUT on each edge. When it reaches 1, state ← N0.
  - Ownership change away from the mouse: state ← N0, and the accumulators are kept.

## Timing
- Reset values: owner_a = owner_b = 0; pa_n = pb_n = 6'b111111; state N0; accumulators, snapshots and nibble = 0; counters 0.
- Outputs are registered.
- Joystick bit change → pX_n change: 1 cycle.
- Activity → owner change: 1 cycle.
- Strobe edge at input in cycle t → new nibble on pX_n at cycle t+2 (synchronizer register plus output register).
- The strobe of a non-owning port is ignored by the sequencer.
- Mid-operation reset returns all state to reset values on the next clock edge.

## Test plan
- Reset, then joy_0=6'b010000 and stra=0 → owner_a=1 after 1 cycle, then pa_n=6'b101111; owner_b=0 and pb_n=6'b111111.
- Swap case: swap=1, joy_0=6'b000001 → owner_b=1; pb_n[0]=0 while strb=0, and 1 while strb=1.
- Mouse read: one mouse_strobe with mouse_x=−5, mouse_y=+3 → owner_a=3; four stra edges give nibbles 0,5,0,3 on pa_n[3:0].
- Saturation and simultaneous events:
  - Three strobes of mouse_x=−100 → snap_x=127.
  - A strobe coincident with the N0 edge → that delta appears only in the next read.
- Displacement: mouse owns A, then joy_0 goes active with owner_b=0 → owner_a=1, owner_b=3, sequencer at N0.
- Timeouts:
  - No stra edge for 100000 cycles after N2 → next edge yields snap_x[7:4] (N0).
  - No activity for IDLE_TIMEOUT cycles → owner returns to 0 and lines return to all 1.
